ef_adc1001_di: RTL

- Capture-side digital interface for a 10-bit SAR ADC hard macro. It is the counterpart of the DAC output interface: samples flow from the analog macro into a FIFO that the bus drains.
- A programmable divider paces conversions. An FSM drives start-of-conversion, waits for a synchronised end-of-conversion, and pushes each result into a show-ahead FIFO.
- Status flags (empty, full, high-water, overrun, late trigger, timeout) feed the register/IRQ wrapper.

---
 rtl/ef_adc_pkg.sv | 15 +
 rtl/ef_sync_fifo.sv | 62 ++++++
 rtl/ef_adc1001_di.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/ef_adc_pkg.sv
// Shared definitions for the ADC capture interface: data/divider widths
// and the conversion FSM state encoding.
package ef_adc_pkg;

    localparam int ADC_DW = 10;
    localparam int DIV_W  = 20;
    localparam int CNT_W  = 16;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        START    = 2'd1,
        WAIT_EOC = 2'd2
    } adc_state_t;

endpackage

// File: rtl/ef_sync_fifo.sv
// Show-ahead synchronous FIFO: rdata always presents the head entry while
// !empty; level counts 0..DEPTH so it needs one bit more than the pointers.
module ef_sync_fifo #(
    parameter int DW = 10,
    parameter int AW = 5
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr,
    input  logic          rd,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] rdata,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   level
);

    localparam int DEPTH = 2 ** AW;
    localparam logic [AW:0] FULL_LVL = (AW + 1)'(DEPTH);

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] w_ptr;
    logic [AW-1:0] r_ptr;
    logic          wr_ok;
    logic          rd_ok;

    // A write into a full FIFO is refused even when a pop happens in the same
    // cycle; the caller flags that as an overrun.
    assign wr_ok = wr & ~full;
    assign rd_ok = rd & ~empty;

    assign full  = (level == FULL_LVL);
    assign empty = (level == '0);
    assign rdata = mem[r_ptr];

    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[w_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            w_ptr <= '0;
            r_ptr <= '0;
            level <= '0;
        end else begin
            if (wr_ok) begin
                w_ptr <= w_ptr + 1'b1;
            end
            if (rd_ok) begin
                r_ptr <= r_ptr + 1'b1;
            end
            case ({wr_ok, rd_ok})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/ef_adc1001_di.sv
// Capture-side interface for a 10-bit SAR ADC macro: divider-paced
// conversions, EOC synchronisation and a show-ahead result FIFO.
module ef_adc1001_di
    import ef_adc_pkg::*;
#(
    parameter int FIFO_AW     = 5,
    parameter int SOC_CYCLES  = 2,
    parameter int EOC_TIMEOUT = 255
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic               clk_en,
    input  logic [DIV_W-1:0]   clkdiv,
    input  logic [FIFO_AW:0]   fifo_threshold,
    input  logic               rd,
    input  logic               flags_clr,
    output logic [ADC_DW-1:0]  rdata,
    output logic               empty,
    output logic               full,
    output logic               high,
    output logic [FIFO_AW:0]   level,
    output logic               ovf,
    output logic               late,
    output logic               tmo,
    output logic               adc_en,
    output logic               adc_soc,
    input  logic               adc_eoc,
    input  logic [ADC_DW-1:0]  adc_data,
    output adc_state_t         fsm_state
);

    localparam logic [CNT_W-1:0] SOC_LAST = CNT_W'(SOC_CYCLES - 1);
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(EOC_TIMEOUT - 1);

    logic [DIV_W-1:0]  div_cnt;
    logic              tick;
    logic              div_run;
    logic              eoc_s1;
    logic              eoc_s2;
    logic              eoc_s3;
    logic              eoc_rise;
    adc_state_t        state;
    adc_state_t        state_nx;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_nx;
    logic              push_nx;
    logic              push_q;
    logic [ADC_DW-1:0] cap_data;
    logic              tmo_set;
    logic              late_set;
    logic              ovf_set;

    assign adc_en    = en;
    assign fsm_state = state;
    assign div_run   = en & clk_en;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            div_cnt <= '0;
            tick    <= 1'b0;
        end else begin
            tick <= 1'b0;
            if (div_run) begin
                if (div_cnt == clkdiv) begin
                    div_cnt <= '0;
                    tick    <= 1'b1;
                end else begin
                    div_cnt <= div_cnt + 1'b1;
                end
            end
        end
    end

    // adc_eoc comes from the analog macro's own timing domain.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            eoc_s1 <= 1'b0;
            eoc_s2 <= 1'b0;
            eoc_s3 <= 1'b0;
        end else begin
            eoc_s1 <= adc_eoc;
            eoc_s2 <= eoc_s1;
            eoc_s3 <= eoc_s2;
        end
    end

    assign eoc_rise = eoc_s2 & ~eoc_s3;

    // cnt times the SOC pulse in START and the timeout in WAIT_EOC.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt + 1'b1;
        push_nx  = 1'b0;
        tmo_set  = 1'b0;
        if (!en) begin
            state_nx = IDLE;
            cnt_nx   = '0;
        end else begin
            case (state)
                IDLE: begin
                    cnt_nx = '0;
                    if (tick) begin
                        state_nx = START;
                    end
                end
                START: begin
                    if (cnt == SOC_LAST) begin
                        state_nx = WAIT_EOC;
                        cnt_nx   = '0;
                    end
                end
                WAIT_EOC: begin
                    if (eoc_rise) begin
                        push_nx  = 1'b1;
                        state_nx = IDLE;
                        cnt_nx   = '0;
                    end else if (cnt == TMO_LAST) begin
                        tmo_set  = 1'b1;
                        state_nx = IDLE;
                        cnt_nx   = '0;
                    end
                end
                default: begin
                    state_nx = IDLE;
                    cnt_nx   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            adc_soc  <= 1'b0;
            push_q   <= 1'b0;
            cap_data <= '0;
        end else begin
            state   <= state_nx;
            cnt     <= cnt_nx;
            adc_soc <= (state_nx == START);
            push_q  <= push_nx;
            if (push_nx) begin
                cap_data <= adc_data;
            end
        end
    end

    // Bus side: rd pops the head only while !empty (ignored otherwise); the
    // converter side pushes once per captured result and never stalls, so a
    // result arriving while full is lost and recorded in ovf.
    ef_sync_fifo #(
        .DW (ADC_DW),
        .AW (FIFO_AW)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .wr    (push_q),
        .rd    (rd),
        .wdata (cap_data),
        .rdata (rdata),
        .full  (full),
        .empty (empty),
        .level (level)
    );

    assign high     = (level > fifo_threshold);
    assign ovf_set  = push_q & full;
    assign late_set = tick & (state != IDLE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ovf  <= 1'b0;
            late <= 1'b0;
            tmo  <= 1'b0;
        end else begin
            ovf  <= ovf_set  | (ovf  & ~flags_clr);
            late <= late_set | (late & ~flags_clr);
            tmo  <= tmo_set  | (tmo  & ~flags_clr);
        end
    end

endmodule
